// File: rtl/pb_press_classifier.sv
// rtl/pb_press_classifier.sv - pushbutton debounce and short/long press classifier
// Active-low button: synchronize, debounce by stability count, then classify hold duration.
module pb_press_classifier #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LONG_CYCLES     = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic PB,
    output logic press,
    output logic release_evt,
    output logic short_press,
    output logic long_press,
    output logic held
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(LONG_CYCLES);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHORT = 2'd1,
        LONG  = 2'd2
    } state_t;

    logic          sync1;
    logic          s;
    logic          db;
    logic [DW-1:0] dcnt;

    state_t        state;
    state_t        state_nxt;
    logic [HW-1:0] hcnt;
    logic [HW-1:0] hcnt_nxt;
    logic          press_nxt;
    logic          release_nxt;
    logic          short_nxt;
    logic          long_nxt;
    logic          held_nxt;

    // Both synchronizer flops idle at the released level so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            s     <= 1'b1;
        end else begin
            sync1 <= PB;
            s     <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db   <= 1'b1;
            dcnt <= '0;
        end else if (s == db) begin
            dcnt <= '0;
        end else if (dcnt == D_LAST) begin
            db   <= s;
            dcnt <= '0;
        end else begin
            dcnt <= dcnt + 1'b1;
        end
    end

    // Release is checked before the long threshold so a coincident release stays short.
    always_comb begin
        state_nxt   = state;
        hcnt_nxt    = hcnt;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        short_nxt   = 1'b0;
        long_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (!db) begin
                    state_nxt = SHORT;
                    press_nxt = 1'b1;
                    hcnt_nxt  = '0;
                end
            end
            SHORT: begin
                if (db) begin
                    state_nxt   = IDLE;
                    release_nxt = 1'b1;
                    short_nxt   = 1'b1;
                end else if (hcnt == H_LAST) begin
                    state_nxt = LONG;
                    long_nxt  = 1'b1;
                end else begin
                    hcnt_nxt = hcnt + 1'b1;
                end
            end
            LONG: begin
                if (db) begin
                    state_nxt   = IDLE;
                    release_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        held_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            hcnt        <= '0;
            press       <= 1'b0;
            release_evt <= 1'b0;
            short_press <= 1'b0;
            long_press  <= 1'b0;
            held        <= 1'b0;
        end else begin
            state       <= state_nxt;
            hcnt        <= hcnt_nxt;
            press       <= press_nxt;
            release_evt <= release_nxt;
            short_press <= short_nxt;
            long_press  <= long_nxt;
            held        <= held_nxt;
        end
    end

endmodule

// File: tb/tb_pb_press_classifier.sv
// tb/tb_pb_press_classifier.sv - self-checking bench for pb_press_classifier
// Behavioural model predicts events from sample history and edges elapsed since the press.
module tb_pb_press_classifier;

    localparam int D = 4;
    localparam int L = 20;

    logic clk;
    logic rst_n;
    logic PB;
    logic press;
    logic release_evt;
    logic short_press;
    logic long_press;
    logic held;

    pb_press_classifier #(
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES    (L)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .PB         (PB),
        .press      (press),
        .release_evt(release_evt),
        .short_press(short_press),
        .long_press (long_press),
        .held       (held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int edge_no = 0;
    int last_press_e, last_rel_e, last_short_e, last_long_e;
    int n_press = 0, n_rel = 0, n_short = 0, n_long = 0;

    bit m_sp1, m_sp2, m_db, m_held, m_long_done;
    bit m_q[$];
    int m_hold;
    bit e_press, e_rel, e_short, e_long;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at edge %0d: got %0d expected %0d", tag, edge_no, got, exp);
        end
    endtask

    task automatic model_reset();
        m_sp1 = 1'b1;
        m_sp2 = 1'b1;
        m_db  = 1'b1;
        m_q.delete();
        m_held = 1'b0;
        m_long_done = 1'b0;
        m_hold = 0;
        e_press = 0; e_rel = 0; e_short = 0; e_long = 0;
    endtask

    // One rising edge: debounced level flips after D consecutive disagreeing synchronized samples.
    task automatic model_step();
        bit s_now, db_old;
        if (!rst_n) begin
            model_reset();
            return;
        end
        s_now  = m_sp2;
        m_sp2  = m_sp1;
        m_sp1  = PB;
        db_old = m_db;
        if (s_now != m_db) begin
            m_q.push_back(s_now);
            if (m_q.size() == D) begin
                m_db = s_now;
                m_q.delete();
            end
        end else begin
            m_q.delete();
        end
        e_press = 0; e_rel = 0; e_short = 0; e_long = 0;
        if (!m_held) begin
            if (!db_old) begin
                e_press = 1; m_held = 1; m_hold = 0; m_long_done = 0;
            end
        end else if (db_old) begin
            e_rel = 1; e_short = !m_long_done; m_held = 0;
        end else if (!m_long_done) begin
            m_hold++;
            if (m_hold == L) begin
                e_long = 1; m_long_done = 1;
            end
        end
    endtask

    task automatic compare_all();
        if (press === 1'b1)       begin n_press++; last_press_e = edge_no; end
        if (release_evt === 1'b1) begin n_rel++;   last_rel_e   = edge_no; end
        if (short_press === 1'b1) begin n_short++; last_short_e = edge_no; end
        if (long_press === 1'b1)  begin n_long++;  last_long_e  = edge_no; end
        check("press", press, e_press);
        check("release_evt", release_evt, e_rel);
        check("short_press", short_press, e_short);
        check("long_press", long_press, e_long);
        check("held", held, m_held);
        check("press_rel_excl", press & release_evt, 0);
        check("short_without_rel", short_press & ~release_evt, 0);
    endtask

    task automatic tick(input logic pb_v);
        PB = pb_v;
        edge_no++;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic clear_marks();
        last_press_e = -1000; last_rel_e = -1000; last_short_e = -1000; last_long_e = -1000;
    endtask

    int first_e, rise_e, np, nr, ns, nl;
    logic lvl;
    int len;

    initial begin
        rst_n = 1'b0;
        PB    = 1'b0;
        model_reset();
        clear_marks();
        #1;
        check("reset_state", {press, release_evt, short_press, long_press, held}, 0);
        @(negedge clk);

        // Reset held with button pressed, then release reset
        repeat (3) tick(1'b0);
        rst_n = 1'b1;
        first_e = edge_no + 1;
        tick(1'b0);
        check("first_cycle_after_reset", {press, release_evt, short_press, long_press, held}, 0);
        repeat (9) tick(1'b0);
        check("rst_press_latency", last_press_e - first_e, 6);
        check("rst_held", held, 1);
        repeat (20) tick(1'b1);

        // Glitch rejection
        np = n_press;
        repeat (5) begin
            repeat (3) tick(1'b0);
            repeat (3) tick(1'b1);
        end
        repeat (10) tick(1'b1);
        check("glitch_no_press", n_press - np, 0);
        check("glitch_held", held, 0);

        // Short press
        clear_marks();
        nl = n_long;
        first_e = edge_no + 1;
        repeat (10) tick(1'b0);
        check("short_press_latency", last_press_e - first_e, 6);
        rise_e = edge_no + 1;
        repeat (15) tick(1'b1);
        check("short_release_latency", last_rel_e - rise_e, 6);
        check("short_with_release", last_short_e - rise_e, 6);
        check("short_no_long", n_long - nl, 0);

        // Long press
        clear_marks();
        nl = n_long; nr = n_rel; ns = n_short;
        repeat (60) tick(1'b0);
        check("long_after_press", last_long_e - last_press_e, L);
        check("long_once", n_long - nl, 1);
        repeat (15) tick(1'b1);
        check("long_release", n_rel - nr, 1);
        check("long_no_short", n_short - ns, 0);

        // Release coincident with the long threshold: release wins
        clear_marks();
        nl = n_long; ns = n_short;
        repeat (L) tick(1'b0);
        repeat (15) tick(1'b1);
        check("boundary_short", n_short - ns, 1);
        check("boundary_no_long", n_long - nl, 0);
        check("boundary_hold_len", last_rel_e - last_press_e, L);

        // One cycle later: long outcome
        nl = n_long; ns = n_short;
        repeat (L + 1) tick(1'b0);
        repeat (15) tick(1'b1);
        check("late_boundary_long", n_long - nl, 1);
        check("late_boundary_no_short", n_short - ns, 0);

        // Reset mid-press
        clear_marks();
        repeat (10) tick(1'b0);
        check("mid_press_held", held, 1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("async_reset_outputs", {press, release_evt, short_press, long_press, held}, 0);
        nr = n_rel; ns = n_short;
        repeat (2) tick(1'b0);
        rst_n = 1'b1;
        first_e = edge_no + 1;
        repeat (10) tick(1'b0);
        check("reset_no_release", n_rel - nr, 0);
        check("reset_no_short", n_short - ns, 0);
        check("repress_latency", last_press_e - first_e, 6);
        repeat (20) tick(1'b1);

        // Randomized segments, biased toward debounce and long-press boundaries
        lvl = 1'b1;
        repeat (200) begin
            lvl = ~lvl;
            case ($urandom_range(0, 3))
                0: len = $urandom_range(1, D + 2);
                1: len = $urandom_range(L - 2, L + 3);
                2: len = $urandom_range(1, 2 * L + 10);
                default: len = $urandom_range(D + 1, 12);
            endcase
            repeat (len) tick(lvl);
        end
        repeat (20) tick(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
